// File: rtl/systolic_pe_acc.sv
// Output-stationary systolic PE: forwards operands east/south, accumulates a K-length
// dot product locally and drains finished results down a per-column result chain.
module systolic_pe_acc #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 24,
   parameter bit          SIGNED = 1'b1,
   parameter bit          SAT    = 1'b1,
   parameter int unsigned K_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] a_in,
   input  logic              a_valid_in,
   input  logic [DATA_W-1:0] b_in,
   input  logic              b_valid_in,
   input  logic [K_W-1:0]    k_len,
   output logic [DATA_W-1:0] a_out,
   output logic              a_valid_out,
   output logic [DATA_W-1:0] b_out,
   output logic              b_valid_out,
   input  logic [ACC_W-1:0]  res_in,
   input  logic              res_sat_in,
   input  logic              res_valid_in,
   output logic [ACC_W-1:0]  res_out,
   output logic              res_sat_out,
   output logic              res_valid_out,
   output logic              busy,
   output logic              ovr_err
);

   localparam int unsigned PW = 2 * DATA_W;
   localparam int unsigned SW = ACC_W + 1;

   typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

   state_e            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [K_W-1:0]    cnt_q, cnt_d;
   logic [K_W-1:0]    klat_q, klat_d;
   logic              sat_q, sat_d;
   logic              ovr_q, ovr_d;
   logic [DATA_W-1:0] a_q, b_q;
   logic              av_q, bv_q;
   logic [ACC_W-1:0]  res_q, res_d;
   logic              rsat_q, rsat_d;
   logic              rvalid_q, rvalid_d;

   logic              fire;
   logic              a_ext, b_ext;
   logic [PW-1:0]     a_x, b_x, prod;
   logic [ACC_W-1:0]  prod_acc;
   logic [SW-1:0]     sum_x;
   logic [ACC_W-1:0]  sum_sat;
   logic              clamp;
   logic [K_W-1:0]    cnt_inc;
   logic [K_W-1:0]    k_eff;
   logic              start;

   assign fire  = a_valid_in & b_valid_in;
   assign a_ext = SIGNED & a_in[DATA_W-1];
   assign b_ext = SIGNED & b_in[DATA_W-1];
   assign a_x   = {{DATA_W{a_ext}}, a_in};
   assign b_x   = {{DATA_W{b_ext}}, b_in};
   // Low PW bits of the extended product are correct for both signed and unsigned operands.
   assign prod  = a_x * b_x;

   always_comb begin
      prod_acc = '0;
      sum_x    = '0;
      if (SIGNED) begin
         prod_acc = ACC_W'($signed(prod));
         sum_x    = SW'($signed(acc_q)) + SW'($signed(prod_acc));
      end else begin
         prod_acc = ACC_W'(prod);
         sum_x    = SW'(acc_q) + SW'(prod_acc);
      end
   end

   always_comb begin
      clamp   = 1'b0;
      sum_sat = sum_x[ACC_W-1:0];
      if (SAT) begin
         if (SIGNED) begin
            if (sum_x[ACC_W] != sum_x[ACC_W-1]) begin
               clamp   = 1'b1;
               sum_sat = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end
         end else if (sum_x[ACC_W]) begin
            clamp   = 1'b1;
            sum_sat = {ACC_W{1'b1}};
         end
      end
   end

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      klat_d  = klat_q;
      sat_d   = sat_q;
      ovr_d   = ovr_q;
      start   = 1'b0;
      k_eff   = (k_len == '0) ? K_W'(1) : k_len;

      unique case (state_q)
         StIdle: begin
            if (fire) start = 1'b1;
         end
         StAcc: begin
            if (fire) begin
               acc_d = sum_sat;
               cnt_d = cnt_inc;
               sat_d = sat_q | clamp;
               if (cnt_inc == klat_q) state_d = StDone;
            end
         end
         StDone: begin
            // A fire always restarts; it only counts as an overwrite when the emit was blocked.
            if (fire) begin
               start = 1'b1;
               if (res_valid_in) ovr_d = 1'b1;
            end else if (!res_valid_in) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (start) begin
         klat_d  = k_eff;
         acc_d   = prod_acc;
         cnt_d   = K_W'(1);
         sat_d   = 1'b0;
         state_d = (k_eff == K_W'(1)) ? StDone : StAcc;
      end
   end

   always_comb begin
      res_d    = res_q;
      rsat_d   = rsat_q;
      rvalid_d = 1'b0;
      if (res_valid_in) begin
         res_d    = res_in;
         rsat_d   = res_sat_in;
         rvalid_d = 1'b1;
      end else if (state_q == StDone) begin
         res_d    = acc_q;
         rsat_d   = sat_q;
         rvalid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         cnt_q    <= '0;
         klat_q   <= '0;
         sat_q    <= 1'b0;
         ovr_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         av_q     <= 1'b0;
         bv_q     <= 1'b0;
         res_q    <= '0;
         rsat_q   <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         klat_q   <= klat_d;
         sat_q    <= sat_d;
         ovr_q    <= ovr_d;
         a_q      <= a_in;
         b_q      <= b_in;
         av_q     <= a_valid_in;
         bv_q     <= b_valid_in;
         res_q    <= res_d;
         rsat_q   <= rsat_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign a_out         = a_q;
   assign a_valid_out   = av_q;
   assign b_out         = b_q;
   assign b_valid_out   = bv_q;
   assign res_out       = res_q;
   assign res_sat_out   = rsat_q;
   assign res_valid_out = rvalid_q;
   assign busy          = (state_q != StIdle);
   assign ovr_err       = ovr_q;

endmodule

// File: tb/tb_systolic_pe_acc.sv
// Directed bench for systolic_pe_acc: a 24-bit saturating PE plus two 16-bit variants
// (saturating and wrapping) sharing one stimulus stream.
module tb_systolic_pe_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  a_in, b_in, k_len;
   logic        a_valid_in, b_valid_in;
   logic [23:0] res_in;
   logic        res_sat_in, res_valid_in;

   logic [7:0]  a_out, b_out;
   logic        a_valid_out, b_valid_out;
   logic [23:0] res_out;
   logic        res_sat_out, res_valid_out, busy, ovr_err;

   logic [7:0]  s_a_out, s_b_out, w_a_out, w_b_out;
   logic        s_av, s_bv, w_av, w_bv;
   logic [15:0] s_res, w_res;
   logic        s_rsat, s_rvalid, s_busy, s_ovr;
   logic        w_rsat, w_rvalid, w_busy, w_ovr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   systolic_pe_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(1'b1), .SAT(1'b1), .K_W(8)) dut (
      .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in),
      .b_valid_in(b_valid_in), .k_len(k_len), .a_out(a_out), .a_valid_out(a_valid_out),
      .b_out(b_out), .b_valid_out(b_valid_out), .res_in(res_in), .res_sat_in(res_sat_in),
      .res_valid_in(res_valid_in), .res_out(res_out), .res_sat_out(res_sat_out),
      .res_valid_out(res_valid_out), .busy(busy), .ovr_err(ovr_err)
   );

   systolic_pe_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SAT(1'b1), .K_W(8)) dut_s16 (
      .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in),
      .b_valid_in(b_valid_in), .k_len(k_len), .a_out(s_a_out), .a_valid_out(s_av),
      .b_out(s_b_out), .b_valid_out(s_bv), .res_in(res_in[15:0]), .res_sat_in(res_sat_in),
      .res_valid_in(res_valid_in), .res_out(s_res), .res_sat_out(s_rsat),
      .res_valid_out(s_rvalid), .busy(s_busy), .ovr_err(s_ovr)
   );

   systolic_pe_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SAT(1'b0), .K_W(8)) dut_w16 (
      .clk(clk), .rst(rst), .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in),
      .b_valid_in(b_valid_in), .k_len(k_len), .a_out(w_a_out), .a_valid_out(w_av),
      .b_out(w_b_out), .b_valid_out(w_bv), .res_in(res_in[15:0]), .res_sat_in(res_sat_in),
      .res_valid_in(res_valid_in), .res_out(w_res), .res_sat_out(w_rsat),
      .res_valid_out(w_rvalid), .busy(w_busy), .ovr_err(w_ovr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [7:0] a, input logic [7:0] b);
      a_in = a; b_in = b; a_valid_in = 1'b1; b_valid_in = 1'b1;
   endtask

   task automatic no_op();
      a_valid_in = 1'b0; b_valid_in = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; set_op(8'h5A, 8'hC3); k_len = 8'd3;
      res_in = 24'h123456; res_sat_in = 1'b1; res_valid_in = 1'b1;
      tick();
      total++;
      if ({a_out, b_out, a_valid_out, b_valid_out} !== 18'h0) begin
         bad++; $display("FAIL reset_fwd: got %h %h %b %b want 0", a_out, b_out, a_valid_out, b_valid_out);
      end
      total++;
      if ({res_out, res_sat_out, res_valid_out} !== 26'h0) begin
         bad++; $display("FAIL reset_res: got %h %b %b want 0", res_out, res_sat_out, res_valid_out);
      end
      total++;
      if ({busy, ovr_err} !== 2'b00) begin
         bad++; $display("FAIL reset_flags: got busy=%b ovr=%b want 0 0", busy, ovr_err);
      end
      rst = 1'b0; no_op(); res_valid_in = 1'b0; res_sat_in = 1'b0; res_in = '0;
      tick();
   endtask

   task automatic test_dot4();
      k_len = 8'd4;
      set_op(8'd3, 8'd5); tick();
      total++;
      if (a_out !== 8'd3 || b_out !== 8'd5 || busy !== 1'b1) begin
         bad++; $display("FAIL dot4_first: got a=%h b=%h busy=%b want 03 05 1", a_out, b_out, busy);
      end
      k_len = 8'd9;
      set_op(8'hFE, 8'd7); tick();
      set_op(8'd10, 8'd10); tick();
      set_op(8'hFF, 8'hFF); tick();
      no_op();
      total++;
      if (res_valid_out !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL dot4_early: got valid=%b busy=%b want 0 1", res_valid_out, busy);
      end
      tick();
      total++;
      if (res_valid_out !== 1'b1 || res_out !== 24'd102 || res_sat_out !== 1'b0) begin
         bad++; $display("FAIL dot4_res: got v=%b %h s=%b want 1 000066 0", res_valid_out, res_out, res_sat_out);
      end
      tick();
      total++;
      if (res_valid_out !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL dot4_after: got valid=%b busy=%b want 0 0", res_valid_out, busy);
      end
   endtask

   task automatic test_saturate();
      k_len = 8'd3;
      for (int i = 0; i < 3; i++) begin
         set_op(8'd127, 8'd127); tick();
      end
      no_op(); tick();
      total++;
      if (s_rvalid !== 1'b1 || s_res !== 16'h7FFF || s_rsat !== 1'b1) begin
         bad++; $display("FAIL sat16: got v=%b %h s=%b want 1 7fff 1", s_rvalid, s_res, s_rsat);
      end
      total++;
      if (w_rvalid !== 1'b1 || w_res !== 16'hBD03 || w_rsat !== 1'b0) begin
         bad++; $display("FAIL wrap16: got v=%b %h s=%b want 1 bd03 0", w_rvalid, w_res, w_rsat);
      end
      total++;
      if (res_out !== 24'd48387 || res_sat_out !== 1'b0) begin
         bad++; $display("FAIL sat24: got %h s=%b want 00bd03 0", res_out, res_sat_out);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      k_len = 8'd0;
      set_op(8'd4, 8'd4); tick();
      no_op();
      total++;
      if (res_valid_out !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL k0_early: got valid=%b busy=%b want 0 1", res_valid_out, busy);
      end
      tick();
      total++;
      if (res_valid_out !== 1'b1 || res_out !== 24'd16) begin
         bad++; $display("FAIL k0_res: got v=%b %h want 1 000010", res_valid_out, res_out);
      end
      k_len = 8'd2;
      set_op(8'd1, 8'd1); tick();
      set_op(8'd1, 8'd1); tick();
      set_op(8'd2, 8'd3); tick();
      total++;
      if (res_valid_out !== 1'b1 || res_out !== 24'd2 || busy !== 1'b1 || ovr_err !== 1'b0) begin
         bad++; $display("FAIL b2b_first: got v=%b %h busy=%b ovr=%b want 1 000002 1 0",
                         res_valid_out, res_out, busy, ovr_err);
      end
      set_op(8'd1, 8'd4); tick();
      no_op(); tick();
      total++;
      if (res_valid_out !== 1'b1 || res_out !== 24'd10 || ovr_err !== 1'b0) begin
         bad++; $display("FAIL b2b_second: got v=%b %h ovr=%b want 1 00000a 0",
                         res_valid_out, res_out, ovr_err);
      end
      tick();
   endtask

   task automatic test_blocked();
      logic [23:0] up [3];
      up[0] = 24'hA1; up[1] = 24'hA2; up[2] = 24'hA3;
      k_len = 8'd1;
      set_op(8'd5, 8'd5); tick();
      no_op();
      for (int i = 0; i < 3; i++) begin
         res_valid_in = 1'b1; res_in = up[i]; res_sat_in = (i == 1);
         tick();
         total++;
         if (res_valid_out !== 1'b1 || res_out !== up[i] || res_sat_out !== (i == 1) || busy !== 1'b1) begin
            bad++; $display("FAIL block_fwd%0d: got v=%b %h s=%b busy=%b want 1 %h %b 1",
                            i, res_valid_out, res_out, res_sat_out, busy, up[i], (i == 1));
         end
      end
      res_valid_in = 1'b0; res_sat_in = 1'b0;
      tick();
      total++;
      if (res_valid_out !== 1'b1 || res_out !== 24'd25 || res_sat_out !== 1'b0 || ovr_err !== 1'b0) begin
         bad++; $display("FAIL block_own: got v=%b %h s=%b ovr=%b want 1 000019 0 0",
                         res_valid_out, res_out, res_sat_out, ovr_err);
      end
      tick();
      // Fire while blocked: 25 is dropped, 4 takes its place.
      set_op(8'd5, 8'd5); tick();
      set_op(8'd2, 8'd2); res_valid_in = 1'b1; res_in = 24'hA1;
      tick();
      no_op(); res_valid_in = 1'b0;
      total++;
      if (res_out !== 24'hA1 || ovr_err !== 1'b1) begin
         bad++; $display("FAIL ovr_set: got %h ovr=%b want 0000a1 1", res_out, ovr_err);
      end
      tick();
      total++;
      if (res_valid_out !== 1'b1 || res_out !== 24'd4 || ovr_err !== 1'b1) begin
         bad++; $display("FAIL ovr_new: got v=%b %h ovr=%b want 1 000004 1", res_valid_out, res_out, ovr_err);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      k_len = 8'd4;
      set_op(8'd1, 8'd1); tick();
      set_op(8'd1, 8'd1); tick();
      rst = 1'b1; set_op(8'd9, 8'd9);
      tick();
      total++;
      if ({a_out, b_out, a_valid_out, b_valid_out, res_out, res_sat_out, res_valid_out,
           busy, ovr_err} !== 46'h0) begin
         bad++; $display("FAIL midrst: got a=%h b=%h res=%h v=%b busy=%b ovr=%b want all 0",
                         a_out, b_out, res_out, res_valid_out, busy, ovr_err);
      end
      rst = 1'b0; k_len = 8'd1;
      set_op(8'd6, 8'hFD); tick();
      no_op(); tick();
      total++;
      if (res_valid_out !== 1'b1 || res_out !== 24'hFFFFEE) begin
         bad++; $display("FAIL midrst_new: got v=%b %h want 1 ffffee", res_valid_out, res_out);
      end
      tick();
   endtask

   task automatic test_forward();
      logic [17:0] exp_fwd;
      logic [17:0] got_fwd;
      for (int i = 0; i < 100; i++) begin
         a_in = 8'($urandom); b_in = 8'($urandom);
         a_valid_in = 1'($urandom); b_valid_in = 1'($urandom);
         k_len = 8'($urandom_range(0, 4));
         exp_fwd = {a_in, b_in, a_valid_in, b_valid_in};
         tick();
         got_fwd = {a_out, b_out, a_valid_out, b_valid_out};
         total++;
         if (got_fwd !== exp_fwd) begin
            bad++; $display("FAIL fwd%0d: got %h want %h", i, got_fwd, exp_fwd);
         end
      end
      no_op();
      tick();
   endtask

   initial begin
      rst = 1'b1; no_op(); a_in = '0; b_in = '0; k_len = '0;
      res_in = '0; res_sat_in = 1'b0; res_valid_in = 1'b0;
      test_reset();
      test_dot4();
      test_saturate();
      test_back_to_back();
      test_blocked();
      test_mid_reset();
      test_forward();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
